// File: rtl/memory_stage_if.sv
// Data-memory bus between the M stage and data memory.
// Request/ready accept phase, then rvalid returns load data or store ack.
interface memory_stage_if;
   logic        req;
   logic        ready;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/memory_stage.sv
// M stage: loads/stores over a variable-latency data bus, stalls upstream
// while an access is outstanding, and drives the M/W pipeline register.
module memory_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   memory_stage_if.master dmem,
   output logic        StallM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW,
   output logic [31:0] PCPlus4W,
   output logic        MisalignW,
   output logic        BusErrW
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;

   logic        regwrite_q, regwrite_d;
   logic [1:0]  resultsrc_q, resultsrc_d;
   logic [31:0] aluresult_q, aluresult_d;
   logic [31:0] readdata_q, readdata_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic        misalign_q, misalign_d;
   logic        buserr_q, buserr_d;

   logic        is_load, is_access, misalign, aligned;
   logic        done, tmo, stall;
   logic [31:0] shifted, load_ext;
   logic [15:0] half;

   always_comb begin
      is_load   = (ResultSrcM == 2'b01);
      is_access = is_load | MemWriteM;
      misalign  = is_access &
                  (((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                   ((Funct3M[1:0] == 2'b10) & (|ALUResultM[1:0])));
      aligned   = is_access & ~misalign;
      done      = (state_q == RESP) & dmem.rvalid;
      // completion wins over a timeout landing in the same cycle
      tmo       = (TIMEOUT_CYCLES != 0) & (state_q != IDLE) &
                  (cnt_q == TIMEOUT_CYCLES) & ~done;
      stall     = aligned & ~done & ~tmo;
   end

   always_comb begin
      dmem.addr  = {ALUResultM[31:2], 2'b00};
      dmem.we    = MemWriteM;
      dmem.be    = 4'b1111;
      dmem.wdata = WriteDataM;
      if (MemWriteM) begin
         unique case (Funct3M[1:0])
            2'b00: begin
               dmem.be    = 4'b0001 << ALUResultM[1:0];
               dmem.wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               dmem.be    = 4'b0011 << {ALUResultM[1], 1'b0};
               dmem.wdata = {2{WriteDataM[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      dmem.req = 1'b0;
      state_d  = state_q;
      unique case (state_q)
         IDLE: begin
            dmem.req = aligned;
            if (aligned) state_d = dmem.ready ? RESP : REQ;
         end
         REQ: begin
            dmem.req = ~tmo;
            if (tmo)             state_d = IDLE;
            else if (dmem.ready) state_d = RESP;
         end
         RESP: begin
            if (done | tmo) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      dmem.req = dmem.req & rst_n;
      if (TIMEOUT_CYCLES == 0 || state_q == IDLE || state_d == IDLE)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 32'd1;
   end

   always_comb begin
      shifted = dmem.rdata >> {ALUResultM[1:0], 3'b000};
      half    = ALUResultM[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
      unique case (Funct3M)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{half[15]}}, half};
         3'b100:  load_ext = {24'd0, shifted[7:0]};
         3'b101:  load_ext = {16'd0, half};
         default: load_ext = dmem.rdata;
      endcase
   end

   // a stalled cycle loads a bubble so an access writes back exactly once
   always_comb begin
      regwrite_d  = 1'b0;
      resultsrc_d = '0;
      aluresult_d = '0;
      readdata_d  = '0;
      rd_d        = '0;
      pcplus4_d   = '0;
      misalign_d  = 1'b0;
      buserr_d    = 1'b0;
      if (!stall) begin
         regwrite_d  = RegWriteM & ~misalign & ~tmo;
         resultsrc_d = ResultSrcM;
         aluresult_d = ALUResultM;
         readdata_d  = (done & is_load) ? load_ext : 32'd0;
         rd_d        = RdM;
         pcplus4_d   = PCPlus4M;
         misalign_d  = misalign;
         buserr_d    = tmo;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         regwrite_q  <= 1'b0;
         resultsrc_q <= '0;
         aluresult_q <= '0;
         readdata_q  <= '0;
         rd_q        <= '0;
         pcplus4_q   <= '0;
         misalign_q  <= 1'b0;
         buserr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         regwrite_q  <= regwrite_d;
         resultsrc_q <= resultsrc_d;
         aluresult_q <= aluresult_d;
         readdata_q  <= readdata_d;
         rd_q        <= rd_d;
         pcplus4_q   <= pcplus4_d;
         misalign_q  <= misalign_d;
         buserr_q    <= buserr_d;
      end
   end

   assign StallM     = stall;
   assign RegWriteW  = regwrite_q;
   assign ResultSrcW = resultsrc_q;
   assign ALUResultW = aluresult_q;
   assign ReadDataW  = readdata_q;
   assign RdW        = rd_q;
   assign PCPlus4W   = pcplus4_q;
   assign MisalignW  = misalign_q;
   assign BusErrW    = buserr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads, stores,
// misalignment, reset mid-access and bus timeout.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;

   logic        StallM, RegWriteW, MisalignW, BusErrW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;

   logic        StallM2, RegWriteW2, MisalignW2, BusErrW2;
   logic [1:0]  ResultSrcW2;
   logic [31:0] ALUResultW2, ReadDataW2, PCPlus4W2;
   logic [4:0]  RdW2;

   int checks = 0;
   int errors = 0;
   int n;

   memory_stage_if bus ();
   memory_stage_if bus2 ();

   always #5 clk = ~clk;

   memory_stage dut (
      .clk(clk), .rst_n(rst_n),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM), .PCPlus4M(PCPlus4M), .dmem(bus),
      .StallM(StallM), .RegWriteW(RegWriteW),
      .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
      .MisalignW(MisalignW), .BusErrW(BusErrW)
   );

   memory_stage #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst_n(rst_n),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM), .PCPlus4M(PCPlus4M), .dmem(bus2),
      .StallM(StallM2), .RegWriteW(RegWriteW2),
      .ResultSrcW(ResultSrcW2), .ALUResultW(ALUResultW2),
      .ReadDataW(ReadDataW2), .RdW(RdW2), .PCPlus4W(PCPlus4W2),
      .MisalignW(MisalignW2), .BusErrW(BusErrW2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      RegWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      MemWriteM  = 1'b0;
      Funct3M    = 3'b000;
      bus.ready  = 1'b0;
      bus.rvalid = 1'b0;
      bus2.ready  = 1'b0;
      bus2.rvalid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rdata,
                          input logic [31:0] exp);
      RegWriteM  = 1'b1;
      ResultSrcM = 2'b01;
      MemWriteM  = 1'b0;
      Funct3M    = f3;
      ALUResultM = a;
      RdM        = 5'd9;
      bus.ready  = 1'b1;
      #1 chk({tag, "_req"}, 32'(bus.req), 32'd1);
      tick();
      bus.ready  = 1'b0;
      bus.rvalid = 1'b1;
      bus.rdata  = rdata;
      #1 chk({tag, "_stall"}, 32'(StallM), 32'd0);
      tick();
      idle();
      chk({tag, "_data"}, ReadDataW, exp);
      chk({tag, "_we"}, 32'(RegWriteW), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      ALUResultM = '0;
      WriteDataM = '0;
      PCPlus4M   = '0;
      RdM        = '0;
      bus.rdata  = '0;
      bus2.rdata = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_regwrite", 32'(RegWriteW), 32'd0);
      chk("rst_alu", ALUResultW, 32'd0);
      chk("rst_req", 32'(bus.req), 32'd0);
      #10 rst_n = 1'b1;
      tick();

      // ALU op passes straight through
      RegWriteM  = 1'b1;
      ALUResultM = 32'h1234;
      RdM        = 5'd5;
      PCPlus4M   = 32'h88;
      #1;
      chk("alu_stall", 32'(StallM), 32'd0);
      chk("alu_req", 32'(bus.req), 32'd0);
      tick();
      idle();
      chk("alu_regwrite", 32'(RegWriteW), 32'd1);
      chk("alu_result", ALUResultW, 32'h1234);
      chk("alu_rd", 32'(RdW), 32'd5);
      chk("alu_pc4", PCPlus4W, 32'h88);

      // LB at 0x103, accepted at once, rvalid next cycle
      RegWriteM  = 1'b1;
      ResultSrcM = 2'b01;
      Funct3M    = 3'b000;
      ALUResultM = 32'h103;
      RdM        = 5'd7;
      bus.ready  = 1'b1;
      #1;
      chk("lb_req", 32'(bus.req), 32'd1);
      chk("lb_addr", bus.addr, 32'h100);
      chk("lb_be", 32'(bus.be), 32'hF);
      chk("lb_we", 32'(bus.we), 32'd0);
      chk("lb_stall0", 32'(StallM), 32'd1);
      tick();
      bus.ready = 1'b0;
      #1;
      chk("lb_req1", 32'(bus.req), 32'd0);
      chk("lb_stall1", 32'(StallM), 32'd1);
      chk("lb_bubble", 32'(RegWriteW), 32'd0);
      tick();
      bus.rvalid = 1'b1;
      bus.rdata  = 32'h80FF_0000;
      #1 chk("lb_stall2", 32'(StallM), 32'd0);
      tick();
      idle();
      chk("lb_data", ReadDataW, 32'hFFFF_FF80);
      chk("lb_regwrite", 32'(RegWriteW), 32'd1);
      chk("lb_rd", 32'(RdW), 32'd7);
      chk("lb_src", 32'(ResultSrcW), 32'd1);
      tick();
      chk("lb_single", 32'(RegWriteW), 32'd0);

      // SH at 0x202 with ready delayed three cycles
      MemWriteM  = 1'b1;
      Funct3M    = 3'b001;
      ALUResultM = 32'h202;
      WriteDataM = 32'hABCD_1234;
      for (int i = 0; i < 4; i++) begin
         bus.ready = (i == 3);
         #1;
         chk("sh_req", 32'(bus.req), 32'd1);
         chk("sh_addr", bus.addr, 32'h200);
         chk("sh_be", 32'(bus.be), 32'hC);
         chk("sh_wdata", bus.wdata, 32'h1234_1234);
         chk("sh_we", 32'(bus.we), 32'd1);
         chk("sh_stall", 32'(StallM), 32'd1);
         tick();
      end
      bus.ready  = 1'b0;
      bus.rvalid = 1'b1;
      #1;
      chk("sh_req_resp", 32'(bus.req), 32'd0);
      chk("sh_ack_stall", 32'(StallM), 32'd0);
      tick();
      idle();
      chk("sh_no_wb", 32'(RegWriteW), 32'd0);

      // SB and SW lanes
      MemWriteM  = 1'b1;
      Funct3M    = 3'b000;
      ALUResultM = 32'h301;
      WriteDataM = 32'h0000_0055;
      #1;
      chk("sb_be", 32'(bus.be), 32'h2);
      chk("sb_wdata", bus.wdata, 32'h5555_5555);
      Funct3M    = 3'b010;
      ALUResultM = 32'h304;
      WriteDataM = 32'hCAFE_F00D;
      #1;
      chk("sw_be", 32'(bus.be), 32'hF);
      chk("sw_wdata", bus.wdata, 32'hCAFE_F00D);
      idle();
      tick();

      // LW at 0x6 is misaligned
      RegWriteM  = 1'b1;
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h6;
      #1;
      chk("mis_req", 32'(bus.req), 32'd0);
      chk("mis_stall", 32'(StallM), 32'd0);
      tick();
      idle();
      chk("mis_flag", 32'(MisalignW), 32'd1);
      chk("mis_regwrite", 32'(RegWriteW), 32'd0);
      tick();
      chk("mis_clear", 32'(MisalignW), 32'd0);

      // extraction variants
      do_load("lh", 3'b001, 32'h42, 32'h8001_0000, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h42, 32'h8001_0000, 32'h0000_8001);
      do_load("lbu", 3'b100, 32'h41, 32'h0000_9A00, 32'h0000_009A);
      do_load("lw", 3'b010, 32'h44, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // reset while waiting in RESP
      RegWriteM  = 1'b1;
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h40;
      bus.ready  = 1'b1;
      tick();
      bus.ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rstr_req", 32'(bus.req), 32'd0);
      chk("rstr_regwrite", 32'(RegWriteW), 32'd0);
      chk("rstr_readdata", ReadDataW, 32'd0);
      #3 rst_n = 1'b1;
      idle();
      tick();
      bus.rvalid = 1'b1;
      bus.rdata  = 32'h1111_2222;
      #1 chk("rstr_stall", 32'(StallM), 32'd0);
      tick();
      idle();
      chk("rstr_late_rv", 32'(RegWriteW), 32'd0);
      chk("rstr_late_data", ReadDataW, 32'd0);
      do_load("post_rst", 3'b010, 32'h40, 32'h1234_5678, 32'h1234_5678);

      // timeout on the TIMEOUT_CYCLES=4 instance
      for (int i = 0; i < 8; i++) tick();
      RegWriteM  = 1'b1;
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h80;
      bus2.ready = 1'b1;
      #1;
      chk("to_req", 32'(bus2.req), 32'd1);
      chk("to_stall0", 32'(StallM2), 32'd1);
      tick();
      bus2.ready = 1'b0;
      n = 0;
      while (StallM2 && n < 20) begin
         tick();
         n++;
      end
      chk("to_release", 32'(StallM2), 32'd0);
      chk("to_req_drop", 32'(bus2.req), 32'd0);
      tick();
      idle();
      chk("to_buserr", 32'(BusErrW2), 32'd1);
      chk("to_regwrite", 32'(RegWriteW2), 32'd0);
      bus2.rvalid = 1'b1;
      bus2.rdata  = 32'h5A5A_5A5A;
      tick();
      bus2.rvalid = 1'b0;
      chk("to_late_rv", 32'(RegWriteW2), 32'd0);
      chk("to_buserr_clr", 32'(BusErrW2), 32'd0);
      chk("to_late_stall", 32'(StallM2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
